// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared types and constants for the posit decode scheduler
package posit_pkg;

  localparam int POSIT_N  = 8;
  localparam int POSIT_ES = 3;
  localparam int POSIT_RS = $clog2(POSIT_N);

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_FMA = 1'b1;

  typedef struct packed {
    logic                sign;
    logic [POSIT_RS+2:0] k;
    logic [POSIT_ES-1:0] exponent;
    logic [POSIT_N-1:0]  mantissa;
    logic                inf;
    logic                zero;
  } decoded_t;

  typedef enum logic [2:0] {IDLE, DEC_A, DEC_B, DEC_C, HOLD} state_t;

  localparam decoded_t DEC_ZERO = '{sign: 1'b0, k: '0, exponent: '0,
                                    mantissa: '0, inf: 1'b0, zero: 1'b1};

endpackage

// File: rtl/posit_decode_scheduler_extract.sv
// rtl/posit_decode_scheduler_extract.sv - combinational posit field decoder
// Zero and NaR report only their flag; other words carry a hidden 1 at mantissa MSB.
module Data_Extraction
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = POSIT_RS
) (
  input  logic [N-1:0] word,
  output decoded_t     dec
);

  logic [N-2:0] rest;
  logic [N-2:0] tail;
  logic [N-2:0] frac;
  logic         rc;
  logic         counting;
  logic [RS:0]  run;
  logic [RS+2:0] run_ext;
  logic         is_zero;
  logic         is_nar;

  assign is_zero = (word == '0);
  assign is_nar  = (word == {1'b1, {(N-1){1'b0}}});
  // Lower bits of the two's complement equal the two's complement of the lower bits.
  assign rest    = word[N-1] ? (~word[N-2:0] + 1'b1) : word[N-2:0];
  assign rc      = rest[N-2];

  always_comb begin
    run      = '0;
    counting = 1'b1;
    for (int i = N-2; i >= 0; i--) begin
      if (counting && (rest[i] == rc)) run = run + 1'b1;
      else counting = 1'b0;
    end
  end

  assign run_ext = {2'b00, run};
  assign tail    = rest << (run + 1'b1);
  assign frac    = tail << ES;

  always_comb begin
    dec = '0;
    if (is_nar) begin
      dec.inf = 1'b1;
    end else if (is_zero) begin
      dec.zero = 1'b1;
    end else begin
      dec.sign     = word[N-1];
      dec.k        = rc ? (run_ext - 1'b1) : (-run_ext);
      dec.exponent = tail[N-2 -: ES];
      dec.mantissa = {1'b1, frac};
    end
  end

endmodule

// File: rtl/posit_decode_scheduler.sv
// rtl/posit_decode_scheduler.sv - decodes a MUL/FMA operand bundle through one shared decoder
module posit_decode_scheduler
  import posit_pkg::*;
#(
  parameter int N  = POSIT_N,
  parameter int ES = POSIT_ES,
  parameter int RS = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_mode,
  output decoded_t     out_a,
  output decoded_t     out_b,
  output decoded_t     out_c,
  output logic         any_nar,
  output logic         any_zero
);

  state_t       state;
  state_t       state_next;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] op_c;
  logic [N-1:0] dec_word;
  decoded_t     dec;
  logic         accept;

  Data_Extraction #(.N(N), .ES(ES), .RS(RS)) u_extract (
    .word (dec_word),
    .dec  (dec)
  );

  assign accept = in_valid && in_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    dec_word   = op_a;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = DEC_A;
      end
      DEC_A: state_next = DEC_B;
      DEC_B: begin
        dec_word   = op_b;
        state_next = (out_mode == MODE_FMA) ? DEC_C : HOLD;
      end
      DEC_C: begin
        dec_word   = op_c;
        state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? DEC_A : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      op_c     <= '0;
      out_mode <= MODE_MUL;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a     <= in_a;
        op_b     <= in_b;
        op_c     <= in_c;
        out_mode <= in_mode;
      end
    end
  end

  // Flags restart on A and accumulate, so they are complete on entry to HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_a    <= '0;
      out_b    <= '0;
      out_c    <= '0;
      any_nar  <= 1'b0;
      any_zero <= 1'b0;
    end else begin
      case (state)
        DEC_A: begin
          out_a    <= dec;
          any_nar  <= dec.inf;
          any_zero <= dec.zero;
        end
        DEC_B: begin
          out_b    <= dec;
          any_nar  <= any_nar | dec.inf;
          any_zero <= any_zero | dec.zero;
          if (out_mode == MODE_MUL) out_c <= DEC_ZERO;
        end
        DEC_C: begin
          out_c    <= dec;
          any_nar  <= any_nar | dec.inf;
          any_zero <= any_zero | dec.zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_decode_scheduler.sv
// tb/tb_posit_decode_scheduler.sv - self-checking bench for posit_decode_scheduler
module tb_posit_decode_scheduler;
  import posit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [7:0] in_a, in_b, in_c;
  logic       out_valid;
  logic       out_ready;
  logic       out_mode;
  decoded_t   out_a, out_b, out_c;
  logic       any_nar, any_zero;

  always #5 clk = ~clk;

  posit_decode_scheduler dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .any_nar(any_nar), .any_zero(any_zero)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic decoded_t mk(input logic s, input int k, input int e,
                                  input logic [7:0] m, input logic inf, input logic z);
    decoded_t d;
    d.sign = s; d.k = k[5:0]; d.exponent = e[2:0];
    d.mantissa = m; d.inf = inf; d.zero = z;
    return d;
  endfunction

  // Walks the word bit by bit: regime run, terminator, exponent, fraction.
  function automatic decoded_t ref_dec(input logic [7:0] w);
    decoded_t d;
    logic [7:0] v;
    int i, run, kk;
    d = '0;
    if (w == 8'h00) begin d.zero = 1'b1; return d; end
    if (w == 8'h80) begin d.inf = 1'b1; return d; end
    d.sign = w[7];
    v = w[7] ? (~w + 8'd1) : w;
    i = 6; run = 0;
    while (i >= 0 && v[i] == v[6]) begin run++; i--; end
    kk = v[6] ? run - 1 : -run;
    d.k = kk[5:0];
    i--;
    for (int e = 2; e >= 0; e--) begin
      d.exponent[e] = (i >= 0) ? v[i] : 1'b0;
      i--;
    end
    d.mantissa[7] = 1'b1;
    for (int m = 6; m >= 0; m--) begin
      d.mantissa[m] = (i >= 0) ? v[i] : 1'b0;
      i--;
    end
    return d;
  endfunction

  typedef struct packed {
    logic     mode;
    decoded_t a, b, c;
    logic     nar, zero;
  } exp_t;

  function automatic exp_t model(input logic m, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c);
    exp_t e;
    e.mode = m;
    e.a = ref_dec(a);
    e.b = ref_dec(b);
    e.c = m ? ref_dec(c) : mk(1'b0, 0, 0, 8'h00, 1'b0, 1'b1);
    e.nar  = e.a.inf  | e.b.inf  | (m & e.c.inf);
    e.zero = e.a.zero | e.b.zero | (m & e.c.zero);
    return e;
  endfunction

  exp_t q[$];
  exp_t mon_e;
  int   pushed = 0;
  int   popped = 0;

  always @(negedge clk) begin
    if (rst) begin
      pushed = pushed - q.size();
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_bundle", 32'd1, 32'd0);
        else begin
          mon_e = q.pop_front();
          popped++;
          chk("sb_mode", out_mode, mon_e.mode);
          chk("sb_a", out_a, mon_e.a);
          chk("sb_b", out_b, mon_e.b);
          chk("sb_c", out_c, mon_e.c);
          chk("sb_any_nar", any_nar, mon_e.nar);
          chk("sb_any_zero", any_zero, mon_e.zero);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_mode, in_a, in_b, in_c));
        pushed++;
      end
    end
  end

  typedef struct {
    logic       mode;
    logic [7:0] a, b, c;
    decoded_t   ea, eb, ec;
    logic       nar, zero;
    int         lat;
  } vec_t;

  vec_t vt[6];

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
      chk("busy_in_ready", in_ready, 1'b0);
    end
  endtask

  // Called at posedge+1; returns at the first negedge with out_valid high.
  task automatic send(input logic m, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, output int lat);
    int n;
    in_valid = 1'b1; in_mode = m; in_a = a; in_b = b; in_c = c;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom); in_mode = ~m;
    wait_valid(lat);
  endtask

  task automatic thru(input logic m, input int gap);
    int t0, n, cyc;
    logic hs;
    in_valid = 1'b1; in_mode = m; out_ready = 1'b1;
    in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom);
    n = 0; cyc = 0; t0 = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        if (n > 0) chk("throughput_gap", cyc - t0, gap);
        t0 = cyc; n++;
        in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom);
      end
    end
    if (n < 3) chk("throughput_timeout", n, 3);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  decoded_t Z, NAR, D40, D60, DC0, D7F, D01, D5B, D23, DA5;
  decoded_t snap_a, snap_b, snap_c;
  int       lat, sent, cyc;
  logic     hs;

  initial begin
    Z   = mk(1'b0,  0, 0, 8'h00, 1'b0, 1'b1);
    NAR = mk(1'b0,  0, 0, 8'h00, 1'b1, 1'b0);
    D40 = mk(1'b0,  0, 0, 8'h80, 1'b0, 1'b0);
    D60 = mk(1'b0,  1, 0, 8'h80, 1'b0, 1'b0);
    DC0 = mk(1'b1,  0, 0, 8'h80, 1'b0, 1'b0);
    D7F = mk(1'b0,  6, 0, 8'h80, 1'b0, 1'b0);
    D01 = mk(1'b0, -6, 0, 8'h80, 1'b0, 1'b0);
    D5B = mk(1'b0,  0, 6, 8'hE0, 1'b0, 1'b0);
    D23 = mk(1'b0, -1, 0, 8'hE0, 1'b0, 1'b0);
    DA5 = mk(1'b1,  0, 6, 8'hE0, 1'b0, 1'b0);
    vt[0] = '{MODE_FMA, 8'h40, 8'h60, 8'h00, D40, D60, Z,   1'b0, 1'b1, 4};
    vt[1] = '{MODE_MUL, 8'h80, 8'h40, 8'h00, NAR, D40, Z,   1'b1, 1'b0, 3};
    vt[2] = '{MODE_MUL, 8'hC0, 8'h7F, 8'h80, DC0, D7F, Z,   1'b0, 1'b0, 3};
    vt[3] = '{MODE_FMA, 8'h5B, 8'h23, 8'hA5, D5B, D23, DA5, 1'b0, 1'b0, 4};
    vt[4] = '{MODE_FMA, 8'h01, 8'h00, 8'h80, D01, Z,   NAR, 1'b1, 1'b1, 4};
    vt[5] = '{MODE_MUL, 8'h00, 8'h01, 8'h5B, Z,   D01, Z,   1'b0, 1'b1, 3};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
    in_a = 8'h00; in_b = 8'h00; in_c = 8'h00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_mode", out_mode, 1'b0);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_out_c", out_c, 32'd0);
    chk("rst_any_nar", any_nar, 1'b0);
    chk("rst_any_zero", any_zero, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      send(vt[i].mode, vt[i].a, vt[i].b, vt[i].c, lat);
      chk("vec_latency", lat, vt[i].lat);
      chk("vec_out_mode", out_mode, vt[i].mode);
      chk("vec_out_a", out_a, vt[i].ea);
      chk("vec_out_b", out_b, vt[i].eb);
      chk("vec_out_c", out_c, vt[i].ec);
      chk("vec_any_nar", any_nar, vt[i].nar);
      chk("vec_any_zero", any_zero, vt[i].zero);
      @(posedge clk); #1;
    end

    // Backpressure in HOLD, then a same-edge accept of the next bundle.
    out_ready = 1'b0;
    send(MODE_FMA, 8'h5B, 8'hC0, 8'h23, lat);
    chk("stall_latency", lat, 4);
    snap_a = out_a; snap_b = out_b; snap_c = out_c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_stable_a", out_a, snap_a);
      chk("stall_stable_b", out_b, snap_b);
      chk("stall_stable_c", out_c, snap_c);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_mode = MODE_FMA;
    in_a = 8'h60; in_b = 8'h01; in_c = 8'h80;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    chk("b2b_latency", lat, 4);
    chk("b2b_out_a", out_a, D60);
    chk("b2b_out_c", out_c, NAR);
    @(posedge clk); #1;

    // Reset while decoding operand B.
    send(MODE_FMA, 8'h5B, 8'h23, 8'h40, lat);
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = MODE_FMA; in_a = 8'h5B; in_b = 8'h23; in_c = 8'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("decb_rst_out_valid", out_valid, 1'b0);
    chk("decb_rst_in_ready", in_ready, 1'b1);
    chk("decb_rst_out_a", out_a, 32'd0);
    chk("decb_rst_out_b", out_b, 32'd0);
    chk("decb_rst_flags", {any_nar, any_zero, out_mode}, 3'b000);
    hs = 1'b0;
    repeat (5) begin @(negedge clk); hs = hs | out_valid; end
    chk("decb_rst_no_output", hs, 1'b0);
    @(posedge clk); #1;

    // Reset wins over a simultaneous handshake.
    rst = 1'b1; in_valid = 1'b1; in_mode = MODE_FMA; in_a = 8'h40;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_prio_in_ready", in_ready, 1'b1);
    chk("rst_prio_out_valid", out_valid, 1'b0);
    @(posedge clk); #1;

    thru(MODE_MUL, 3);
    thru(MODE_FMA, 4);

    // Random mixed stream with random downstream backpressure.
    sent = 0; cyc = 0;
    in_valid = 1'b1; in_mode = 1'($urandom);
    in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom);
    while (sent < 40 && cyc < 2000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        sent++;
        in_mode = 1'($urandom);
        in_a = 8'($urandom); in_b = 8'($urandom); in_c = 8'($urandom);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stream_sent", sent, 40);
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin @(posedge clk); cyc++; end
    #1;
    chk("stream_drained", q.size(), 0);
    chk("stream_in_order_count", popped, pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_decode_scheduler.md
POSIT_DECODE_SCHEDULER -- requirements
Module: posit_decode_scheduler

Interface
REQ-001 SHALL have parameter N, default 8, posit word width.
REQ-002 SHALL have parameter ES, default 3, exponent field width.
REQ-003 SHALL have parameter RS, default $clog2(N), regime-count width base; k width is RS+3.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand bundle offered.
REQ-007 SHALL have port in_ready  output  1  bundle accepted when in_valid&in_ready.
REQ-008 SHALL have port in_mode  input  1  0 = MUL (A,B), 1 = FMA (A,B,C).
REQ-009 SHALL have ports in_a, in_b, in_c  input  N each  posit operands.
REQ-010 SHALL have port out_valid  output  1  decoded bundle available.
REQ-011 SHALL have port out_ready  input  1  downstream takes bundle when out_valid&out_ready.
REQ-012 SHALL have port out_mode  output  1  captured in_mode.
REQ-013 SHALL have ports out_a, out_b, out_c  output  decoded_t each  {sign, k[RS+2:0], exponent[ES-1:0], mantissa[N-1:0], inf, zero}.
REQ-014 SHALL have ports any_nar, any_zero  output  1 each  OR of inf / zero over decoded operands.

Function
REQ-015 SHALL time-share one posit field decoder across the operands, one operand per cycle.
REQ-016 SHALL implement FSM states IDLE, DEC_A, DEC_B, DEC_C, HOLD.
REQ-017 IDLE: in_ready=1; on handshake, capture in_a/b/c/mode into operand registers and go to DEC_A.
REQ-018 DEC_A -> DEC_B unconditionally; DEC_B -> DEC_C if mode=FMA, else -> HOLD; DEC_C -> HOLD.
REQ-019 In each DEC_x state, decoder input SHALL be the captured operand x; its outputs SHALL be registered into out_x at the state's end edge.
REQ-020 In MUL mode, out_c SHALL be forced to the zero encoding (zero=1, all other fields 0), and C SHALL NOT contribute to any_nar/any_zero.
REQ-021 HOLD: out_valid=1; outputs SHALL remain stable until out_ready=1.
REQ-022 in_ready SHALL be 1 in IDLE and in HOLD when out_ready=1 (back-to-back); an accept in HOLD SHALL go directly to DEC_A.
REQ-023 HOLD with out_ready=1 and no new in_valid SHALL return to IDLE.
REQ-024 Latency: handshake at edge t -> out_valid high from t+3 (MUL) or t+4 (FMA).
REQ-025 Sustained throughput SHALL be one bundle per 3 cycles (MUL) or 4 cycles (FMA).
REQ-026 in_valid while in DEC_x SHALL be ignored (in_ready=0); inputs SHALL be sampled only on handshake.
REQ-027 any_nar/any_zero SHALL be registered and valid with out_valid.
REQ-028 Decoded fields SHALL be bit-identical to a standalone Data_Extraction instance given the same word.

Reset
REQ-029 On rst=1 at an edge, FSM SHALL enter IDLE regardless of state, including mid-decode or HOLD; in-flight bundle discarded.
REQ-030 Reset values: out_valid=0, in_ready=1 (first cycle after reset), out_mode=0, out_a/b/c all zero, any_nar=0, any_zero=0.
REQ-031 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-032 Package posit_pkg SHALL hold decoded_t struct, state enum, and mode constants MODE_MUL/MODE_FMA.
REQ-033 SHALL instantiate exactly one Data_Extraction sub-module fed by a state-driven operand mux.
REQ-034 SHALL contain no combinational path from in_* to out_*.

Verification
REQ-035 FMA, A=0x40, B=0x60, C=0x00, out_ready=1 -> out_valid at t+4; out_a.k=0, exp=0; out_b.k=1; out_c.zero=1; any_zero=1, any_nar=0.
REQ-036 MUL, A=0x80, B=0x40 -> out_valid at t+3; out_a.inf=1, any_nar=1; out_c zero encoding; any_zero=0.
REQ-037 A=0xC0 (-1) -> out_a.sign=1, k=0, exp=0, mantissa equal to standalone decoder output.
REQ-038 out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0; then out_ready=1 with in_valid=1 -> accepted same edge, next out_valid 4 cycles later (FMA).
REQ-039 rst asserted in DEC_B -> next cycle IDLE, out_valid=0, in_ready=1, outputs zero.
REQ-040 Random back-to-back mixed MUL/FMA stream vs reference model -> all bundles in order, none dropped or duplicated.
